// File: rtl/div_cfg_arbiter_pkg.sv
// Shared definitions for the divider-configuration arbiter: FSM encoding,
// default geometry and the width of requester indices.
package div_cfg_arbiter_pkg;

  localparam int DEF_NOB        = 4;
  localparam int DEF_NREQ       = 4;
  localparam int DEF_SETTLE_CYC = 8;
  localparam int ID_W           = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_SETTLE = 2'd2,
    ST_ACK    = 2'd3
  } state_e;

endpackage

// File: rtl/div_cfg_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request bit searching upward
// from last_winner+1, wrapping at NREQ.
module rr_pick
  import div_cfg_arbiter_pkg::*;
#(
  parameter int NREQ = DEF_NREQ
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] last_winner,
  output logic [ID_W-1:0] index,
  output logic            any
);

  // Scan from the farthest offset down so the nearest set bit overwrites last.
  always_comb begin
    int pos;
    pos   = 0;
    index = {ID_W{1'b0}};
    any   = 1'b0;
    for (int off = NREQ; off >= 1; off--) begin
      pos   = (int'(last_winner) + off) % NREQ;
      index = req[pos] ? ID_W'(pos) : index;
      any   = any | req[pos];
    end
  end

endmodule

// File: rtl/div_cfg_arbiter.sv
// Arbitrates divide-ratio change requests, strobes the winning ratio into the
// divider, waits for it to settle and acknowledges the requester.
module div_cfg_arbiter
  import div_cfg_arbiter_pkg::*;
#(
  parameter int NOB        = DEF_NOB,
  parameter int NREQ       = DEF_NREQ,
  parameter int SETTLE_CYC = DEF_SETTLE_CYC
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NREQ-1:0]     req,
  input  logic [NREQ*NOB-1:0] req_ratio,
  output logic [NREQ-1:0]     gnt,
  output logic                done,
  output logic [ID_W-1:0]     done_id,
  output logic                err,
  output logic                ratio_setting,
  output logic [NOB-1:0]      divide_ratio,
  output logic [NOB-1:0]      cur_ratio,
  output logic                busy
);

  localparam int              CNT_W    = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYC - 1);
  localparam logic [ID_W-1:0] LAST_RST = ID_W'(NREQ - 1);
  localparam logic [NREQ-1:0] GNT_ONE  = {{(NREQ-1){1'b0}}, 1'b1};

  state_e          state_r, state_s;
  logic [ID_W-1:0] winner_r, last_winner_r, pick_idx_s;
  logic [NOB-1:0]  ratio_lat_r, pick_ratio_s;
  logic [CNT_W-1:0] cnt_r;
  logic            pick_any_s, accept_s, lat_zero_s;

  logic [NREQ-1:0] gnt_r, gnt_s;
  logic            done_r, done_s, err_r, err_s, set_r, set_s, busy_r, busy_s;
  logic [ID_W-1:0] done_id_r, done_id_s;
  logic [NOB-1:0]  div_r, div_s, cur_r, cur_s;

  rr_pick #(.NREQ(NREQ)) u_rr_pick (
    .req         (req),
    .last_winner (last_winner_r),
    .index       (pick_idx_s),
    .any         (pick_any_s)
  );

  assign pick_ratio_s = req_ratio[int'(pick_idx_s)*NOB +: NOB];
  assign accept_s     = (state_r == ST_IDLE) && pick_any_s;
  assign lat_zero_s   = (ratio_lat_r == {NOB{1'b0}});

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_r <= ST_IDLE;
    else        state_r <= state_s;
  end

  // Next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE:   if (pick_any_s) state_s = ST_LOAD; else state_s = ST_IDLE;
      ST_LOAD:   if (lat_zero_s) state_s = ST_ACK; else state_s = ST_SETTLE;
      ST_SETTLE: if (cnt_r == {CNT_W{1'b0}}) state_s = ST_ACK; else state_s = ST_SETTLE;
      ST_ACK:    state_s = ST_IDLE;
      default:   state_s = ST_IDLE;
    endcase
  end

  // Winner/ratio capture, settle counter and round-robin history.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      winner_r      <= {ID_W{1'b0}};
      ratio_lat_r   <= {NOB{1'b0}};
      cnt_r         <= {CNT_W{1'b0}};
      last_winner_r <= LAST_RST;
    end else begin
      if (accept_s) begin
        winner_r    <= pick_idx_s;
        ratio_lat_r <= pick_ratio_s;
      end
      if (state_r == ST_LOAD) cnt_r <= CNT_LOAD;
      else if ((state_r == ST_SETTLE) && (cnt_r != {CNT_W{1'b0}})) cnt_r <= cnt_r - CNT_W'(1'b1);
      if (state_r == ST_ACK) last_winner_r <= winner_r;
    end
  end

  // Output decode, evaluated one cycle ahead so every output is a flop.
  always_comb begin
    if (state_s == ST_IDLE) gnt_s = {NREQ{1'b0}};
    else if (accept_s)      gnt_s = GNT_ONE << pick_idx_s;
    else                    gnt_s = gnt_r;
    set_s = accept_s && (pick_ratio_s != {NOB{1'b0}});
    if ((state_r == ST_LOAD) && !lat_zero_s) cur_s = ratio_lat_r;
    else                                     cur_s = cur_r;
    if (set_s) div_s = pick_ratio_s;
    else       div_s = cur_s;
    done_s = (state_s == ST_ACK);
    if (done_s) done_id_s = winner_r;
    else        done_id_s = {ID_W{1'b0}};
    err_s  = done_s && lat_zero_s;
    busy_s = (state_s != ST_IDLE);
  end

  // Output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gnt_r     <= {NREQ{1'b0}};
      done_r    <= 1'b0;
      done_id_r <= {ID_W{1'b0}};
      err_r     <= 1'b0;
      set_r     <= 1'b0;
      div_r     <= {NOB{1'b0}};
      cur_r     <= {NOB{1'b0}};
      busy_r    <= 1'b0;
    end else begin
      gnt_r     <= gnt_s;
      done_r    <= done_s;
      done_id_r <= done_id_s;
      err_r     <= err_s;
      set_r     <= set_s;
      div_r     <= div_s;
      cur_r     <= cur_s;
      busy_r    <= busy_s;
    end
  end

  assign gnt           = gnt_r;
  assign done          = done_r;
  assign done_id       = done_id_r;
  assign err           = err_r;
  assign ratio_setting = set_r;
  assign divide_ratio  = div_r;
  assign cur_ratio     = cur_r;
  assign busy          = busy_r;

endmodule

// File: tb/tb_div_cfg_arbiter.sv
// Directed bench for div_cfg_arbiter; expected completions are queued when a
// request is driven and matched against ratio_setting/done as they appear.
module tb_div_cfg_arbiter;

  localparam int NOB  = 4;
  localparam int NREQ = 4;
  localparam int SC   = 8;

  logic                clk = 1'b0;
  logic                reset = 1'b0;
  logic [NREQ-1:0]     req = '0;
  logic [NREQ*NOB-1:0] req_ratio = '0;
  logic [NREQ-1:0]     gnt;
  logic                done, err, ratio_setting, busy;
  logic [2:0]          done_id;
  logic [NOB-1:0]      divide_ratio, cur_ratio;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int model_cur = 0;

  typedef struct {
    int id; int err; int ratio; int set_cyc; int done_cyc; int cur_after;
  } exp_t;
  exp_t q[$];

  div_cfg_arbiter #(.NOB(NOB), .NREQ(NREQ), .SETTLE_CYC(SC)) dut (
    .clk(clk), .reset(reset), .req(req), .req_ratio(req_ratio),
    .gnt(gnt), .done(done), .done_id(done_id), .err(err),
    .ratio_setting(ratio_setting), .divide_ratio(divide_ratio),
    .cur_ratio(cur_ratio), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Queue the expected outcome of a request accepted at edge n.
  task automatic push(input int id, input int ratio, input int n);
    exp_t e;
    e.id       = id;
    e.ratio    = ratio;
    e.err      = (ratio == 0) ? 1 : 0;
    e.set_cyc  = (ratio == 0) ? -1 : n;
    e.done_cyc = (ratio == 0) ? n + 1 : n + 1 + SC;
    if (ratio != 0) model_cur = ratio;
    e.cur_after = model_cur;
    q.push_back(e);
  endtask

  task automatic wait_done(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
    check(tag, {31'd0, seen}, 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt"}, {28'd0, gnt}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_done_id"}, {29'd0, done_id}, 32'd0);
    check({tag, "_err"}, {31'd0, err}, 32'd0);
    check({tag, "_set"}, {31'd0, ratio_setting}, 32'd0);
    check({tag, "_div"}, {28'd0, divide_ratio}, 32'd0);
    check({tag, "_cur"}, {28'd0, cur_ratio}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  // Scoreboard: match strobes and completions against the expectation queue.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      if (q.size() == 0) begin
        check("quiet", {29'd0, done, ratio_setting, err}, 32'd0);
      end else begin
        if (ratio_setting) begin
          check("set_cycle", cyc, q[0].set_cyc);
          check("set_ratio", {28'd0, divide_ratio}, q[0].ratio);
          q[0].set_cyc = -2;
        end
        if (done) begin
          e = q.pop_front();
          check("done_cycle", cyc, e.done_cyc);
          check("done_id", {29'd0, done_id}, e.id);
          check("done_err", {31'd0, err}, e.err);
          check("gnt_at_done", {28'd0, gnt}, 32'd1 << e.id);
          check("cur_ratio", {28'd0, cur_ratio}, e.cur_after);
          check("div_hold", {28'd0, divide_ratio}, e.cur_after);
          check("setting_seen", e.set_cyc, (e.err != 0) ? -1 : -2);
        end else begin
          check("err_without_done", {31'd0, err}, 32'd0);
        end
      end
    end
  end

  initial begin
    int n;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b1;
    @(negedge clk);

    // Contention: all four held, ratios 2..5 -> grants 0,1,2,3,0.
    req_ratio = {4'd5, 4'd4, 4'd3, 4'd2};
    req = 4'b1111;
    n = cyc + 1;
    for (int k = 0; k < 5; k++) begin
      push(k % 4, (k % 4) + 2, n);
      n = n + SC + 3;
    end
    @(negedge clk);
    check("cont_gnt", {28'd0, gnt}, 32'd1);
    check("cont_busy", {31'd0, busy}, 32'd1);
    for (int k = 0; k < 5; k++) wait_done("cont_done_timeout");
    req = 4'b0000;
    @(negedge clk);

    // Single request, ratio 6 on slot 2.
    req_ratio = {4'd1, 4'd6, 4'd1, 4'd1};
    req = 4'b0100;
    push(2, 6, cyc + 1);
    @(negedge clk);
    check("single_gnt", {28'd0, gnt}, 32'd4);
    wait_done("single_done_timeout");
    req = 4'b0000;
    @(negedge clk);

    // Zero ratio is rejected with err and leaves cur_ratio alone.
    req_ratio = 16'h1110;
    req = 4'b0001;
    push(0, 0, cyc + 1);
    wait_done("zero_done_timeout");
    req = 4'b0000;
    @(negedge clk);

    // Withdrawal and ratio change after acceptance.
    req_ratio = 16'h0030;
    req = 4'b0010;
    push(1, 3, cyc + 1);
    repeat (4) @(negedge clk);
    req = 4'b0000;
    req_ratio = 16'h0090;
    wait_done("withdraw_done_timeout");
    @(negedge clk);

    // Reset in the middle of SETTLE aborts silently.
    req_ratio = 16'h0007;
    req = 4'b0001;
    push(0, 7, cyc + 1);
    repeat (4) @(negedge clk);
    reset = 1'b0;
    #1;
    check_all_zero("midreset");
    q.delete();
    model_cur = 0;
    repeat (2) begin
      @(negedge clk);
      check("inreset_done", {31'd0, done}, 32'd0);
    end
    reset = 1'b1;
    push(0, 7, cyc + 1);
    wait_done("postreset_done_timeout");
    req = 4'b0000;
    @(negedge clk);

    // Wrap: make 3 the last winner, then 4'b1001 must go to 0.
    req_ratio = 16'h4000;
    req = 4'b1000;
    push(3, 4, cyc + 1);
    wait_done("wrap_a_done_timeout");
    req = 4'b0000;
    @(negedge clk);
    req_ratio = 16'h1005;
    req = 4'b1001;
    push(0, 5, cyc + 1);
    wait_done("wrap_b_done_timeout");
    req = 4'b0000;

    repeat (3) @(negedge clk);
    check("end_busy", {31'd0, busy}, 32'd0);
    check("end_gnt", {28'd0, gnt}, 32'd0);
    check("end_cur", {28'd0, cur_ratio}, 32'd5);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/div_cfg_arbiter.md
DIV_CFG_ARBITER -- requirements
Module: div_cfg_arbiter

Interface
REQ-001 Parameter NOB, default 4, width of divide ratio; SHALL match the driven divider's NOB.
REQ-002 Parameter NREQ, default 4, number of requesters; SHALL be 2..8.
REQ-003 Parameter SETTLE_CYC, default 8, cycles waited after a ratio load before acknowledging; SHALL be >= 1.
REQ-004 clk  input  1  single clock; all state on posedge clk.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 req  input  NREQ  per-requester level request; held high until own done.
REQ-007 req_ratio  input  NREQ*NOB  requested ratio, slice i = bits [i*NOB +: NOB].
REQ-008 gnt  output  NREQ  one-hot grant; high from acceptance through done cycle.
REQ-009 done  output  1  one-cycle completion pulse.
REQ-010 done_id  output  3  index of requester completed; valid only with done.
REQ-011 err  output  1  one-cycle pulse with done when the requested ratio was 0 (rejected).
REQ-012 ratio_setting  output  1  one-cycle load strobe to divider.
REQ-013 divide_ratio  output  NOB  ratio presented to divider; valid while ratio_setting high.
REQ-014 cur_ratio  output  NOB  last ratio successfully loaded.
REQ-015 busy  output  1  high in any state other than IDLE.

Function
REQ-016 FSM states IDLE, LOAD, SETTLE, ACK; one-hot or binary encoding permitted.
REQ-017 IDLE: if any req bit high at the edge, SHALL latch winner index and its req_ratio, set gnt, go to LOAD; else stay.
REQ-018 Winner SHALL be round-robin: first set bit searching upward from (last_winner+1) mod NREQ, wrapping; last_winner resets to NREQ-1 so requester 0 wins first.
REQ-019 LOAD (exactly one cycle): latched ratio nonzero -> ratio_setting=1, divide_ratio=latched ratio, cur_ratio updated at end of cycle, go to SETTLE with counter=SETTLE_CYC-1; latched ratio zero -> no strobe, cur_ratio unchanged, go to ACK with err flagged.
REQ-020 SETTLE: counter decrements each cycle; at 0 go to ACK; total SETTLE_CYC cycles.
REQ-021 ACK (exactly one cycle): done=1, done_id=winner, err as flagged, gnt still high; last_winner updated; next state IDLE, gnt cleared.
REQ-022 Latency: req sampled at edge N -> ratio_setting high in cycle N+1 -> done high in cycle N+2+SETTLE_CYC; zero-ratio request done in cycle N+2.
REQ-023 Requests arriving or dropping while busy SHALL NOT affect the operation in flight; dropped req after grant still completes with done.
REQ-024 req_ratio changes after acceptance SHALL be ignored (latched value used).
REQ-025 Back-to-back: minimum one IDLE cycle between done and next acceptance.
REQ-026 divide_ratio SHALL hold cur_ratio when ratio_setting low.

Reset
REQ-027 Reset low asynchronously forces IDLE; gnt=0, done=0, done_id=0, err=0, ratio_setting=0, divide_ratio=0, cur_ratio=0, busy=0, counter=0, last_winner=NREQ-1.
REQ-028 Reset mid-operation SHALL abort without a done pulse; first edge after release samples req in IDLE.

Structure
REQ-029 Shared package holds FSM state encodings and the default NOB/NREQ/SETTLE_CYC constants.
REQ-030 Round-robin priority picker SHALL be one combinational sub-module rr_pick (inputs req, last_winner; outputs index, any).

Verification
REQ-031 Single request: req=4'b0100, ratio slice2=6 -> gnt=4'b0100, ratio_setting one cycle with divide_ratio=6 at N+1, done with done_id=2 at N+10, cur_ratio=6.
REQ-032 Contention: req=4'b1111 held, ratios 2,3,4,5 -> grants in order 0,1,2,3,0, each done 11 cycles after prior done+1 idle cycle.
REQ-033 Zero ratio: req=4'b0001, ratio=0 -> no ratio_setting, done+err with done_id=0 at N+2, cur_ratio unchanged.
REQ-034 Withdrawal: req1 accepted, dropped in SETTLE, req_ratio changed 3->9 -> load uses 3, done_id=1 still pulses.
REQ-035 Reset mid-SETTLE: reset low 2 cycles -> all outputs zero immediately, no done, requester 0 wins next if pending.
REQ-036 Wrap: last_winner=3, req=4'b1001 -> requester 0 granted.
